// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute bus, extracts/extends load data
// from the synchronous SRAM, and holds that data while write-back stalls.
module mem_stage #(
    parameter int EXE_TO_MEM_BUS_WD = 75,
    parameter int MEM_TO_WB_BUS_WD  = 70
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         exe_to_mem_valid,
    input  logic [EXE_TO_MEM_BUS_WD-1:0] exe_to_mem_bus,
    output logic                         mem_allowin,
    input  logic                         wb_allowin,
    output logic                         mem_to_wb_valid,
    output logic [MEM_TO_WB_BUS_WD-1:0]  mem_to_wb_bus,
    input  logic [31:0]                  data_sram_rdata,
    output logic                         gr_we_mem,
    output logic [4:0]                   dest_mem,
    output logic [31:0]                  forward_data_mem
);

    logic                         mem_valid_q;
    logic                         first_cycle_q;
    logic                         buf_valid_q;
    logic [31:0]                  rdata_buf_q;
    logic [EXE_TO_MEM_BUS_WD-1:0] bus_q;

    logic        mem_ready_go;
    logic        ld_b, ld_h, ld_w, ld_bu, ld_hu;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result, pc;
    logic [31:0] raw_data, load_data, final_result;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign mem_ready_go    = 1'b1;
    assign mem_allowin     = !mem_valid_q || (mem_ready_go && wb_allowin);
    assign mem_to_wb_valid = mem_valid_q && mem_ready_go;

    assign {ld_b, ld_h, ld_w, ld_bu, ld_hu} = bus_q[74:70];
    assign gr_we      = bus_q[69];
    assign dest       = bus_q[68:64];
    assign alu_result = bus_q[63:32];
    assign pc         = bus_q[31:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q   <= 1'b0;
            first_cycle_q <= 1'b0;
            buf_valid_q   <= 1'b0;
        end else begin
            if (mem_allowin)
                mem_valid_q <= exe_to_mem_valid;
            first_cycle_q <= exe_to_mem_valid && mem_allowin;
            // SRAM data is only good in the first cycle; keep it if we cannot leave yet
            if (mem_valid_q && wb_allowin)
                buf_valid_q <= 1'b0;
            else if (mem_valid_q && first_cycle_q)
                buf_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (exe_to_mem_valid && mem_allowin)
            bus_q <= exe_to_mem_bus;
        if (mem_valid_q && first_cycle_q && !wb_allowin)
            rdata_buf_q <= data_sram_rdata;
    end

    assign raw_data = buf_valid_q ? rdata_buf_q : data_sram_rdata;

    always_comb begin
        byte_sel = raw_data[7:0];
        case (alu_result[1:0])
            2'd0: byte_sel = raw_data[7:0];
            2'd1: byte_sel = raw_data[15:8];
            2'd2: byte_sel = raw_data[23:16];
            2'd3: byte_sel = raw_data[31:24];
            default: byte_sel = raw_data[7:0];
        endcase
        half_sel = alu_result[1] ? raw_data[31:16] : raw_data[15:0];

        load_data = raw_data;
        if (ld_b)       load_data = {{24{byte_sel[7]}}, byte_sel};
        else if (ld_bu) load_data = {24'd0, byte_sel};
        else if (ld_h)  load_data = {{16{half_sel[15]}}, half_sel};
        else if (ld_hu) load_data = {16'd0, half_sel};
        else if (ld_w)  load_data = raw_data;
    end

    assign final_result = (ld_b || ld_h || ld_w || ld_bu || ld_hu) ? load_data : alu_result;

    assign mem_to_wb_bus    = {gr_we, dest, final_result, pc};
    assign gr_we_mem        = mem_valid_q && gr_we;
    assign dest_mem         = mem_valid_q ? dest : 5'd0;
    assign forward_data_mem = mem_valid_q ? final_result : 32'd0;

endmodule
